seq_divider: RTL and testbench

Multi-cycle 32-bit integer divider for the pipelined MIPS datapath, implementing DIV/DIVU by repeated shift-and-subtract. It is the subtractive counterpart of the combinational `Adder` in the EX stage. It sits beside the ALU and is started from EX. HI/LO-style results are returned after a fixed latency while the hazard unit stalls on `Busy`.

---
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for DIV/DIVU (LO = quotient, HI = remainder).
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst        - asynchronous active-low reset
//   Start      - request a divide (sampled only in IDLE)
//   Signed     - 1 = two's complement divide, 0 = unsigned (sampled with Start)
//   Dividend   - numerator (sampled with Start)
//   Divisor    - denominator (sampled with Start)
//   Busy       - high whenever the FSM is not in IDLE
//   Done       - one-cycle pulse, results valid in that cycle
//   Quotient   - LO result, held until the next Done
//   Remainder  - HI result, held until the next Done
//   DivByZero  - divide-by-zero flag of the last completed operation
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic             sign_q, sign_q_nxt;
  logic             sign_r, sign_r_nxt;
  logic             zero, zero_nxt;

  logic             busy_nxt;
  logic             done_nxt;
  logic             dbz_nxt;
  logic [WIDTH-1:0] quotient_nxt;
  logic [WIDTH-1:0] remainder_nxt;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [RW-1:0]    shifted;
  logic [RW-1:0]    trial;

  // Operand magnitudes; abs(most negative) wraps to itself and is read as unsigned.
  always_comb begin
    dividend_mag = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    divisor_mag  = (Signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
  end

  // One restoring step: the trial subtract is one bit wider so it never wraps.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rem_nxt       = rem;
    quo_nxt       = quo;
    dvs_nxt       = dvs;
    sign_q_nxt    = sign_q;
    sign_r_nxt    = sign_r;
    zero_nxt      = zero;
    done_nxt      = 1'b0;
    dbz_nxt       = DivByZero;
    quotient_nxt  = Quotient;
    remainder_nxt = Remainder;

    case (state)
      IDLE: begin
        if (Start) begin
          cnt_nxt = '0;
          rem_nxt = '0;
          if (Divisor == '0) begin
            // Keep the raw dividend in quo; it becomes the remainder in FIX.
            quo_nxt    = Dividend;
            dvs_nxt    = '0;
            sign_q_nxt = 1'b0;
            sign_r_nxt = 1'b0;
            zero_nxt   = 1'b1;
            state_nxt  = FIX;
          end else begin
            quo_nxt    = dividend_mag;
            dvs_nxt    = divisor_mag;
            sign_q_nxt = Signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            sign_r_nxt = Signed & Dividend[WIDTH-1];
            zero_nxt   = 1'b0;
            state_nxt  = RUN;
          end
        end
      end

      RUN: begin
        if (!trial[RW-1]) begin
          rem_nxt = trial[WIDTH-1:0];
          quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_nxt = shifted[WIDTH-1:0];
          quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = FIX;
        end
      end

      FIX: begin
        if (zero) begin
          quotient_nxt  = '1;
          remainder_nxt = quo;
        end else begin
          quotient_nxt  = sign_q ? -quo : quo;
          remainder_nxt = sign_r ? -rem : rem;
        end
        dbz_nxt   = zero;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero      <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rem       <= rem_nxt;
      quo       <= quo_nxt;
      dvs       <= dvs_nxt;
      sign_q    <= sign_q_nxt;
      sign_r    <= sign_r_nxt;
      zero      <= zero_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      DivByZero <= dbz_nxt;
      Quotient  <= quotient_nxt;
      Remainder <= remainder_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider. Stimulus pushes expected
// results into a queue; a monitor pops and compares on every Done pulse.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        Signed;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Signed    (Signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every Done cycle must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && Done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got Q=%h R=%h expected no Done", Quotient, Remainder);
        end else begin
          e = sb.pop_front();
          check("quotient", Quotient, e.q);
          check("remainder", Remainder, e.r);
          check("divbyzero", 32'(DivByZero), 32'(e.dbz));
        end
      end
    end
  end

  // Drive one request; returns just after the sampling edge with operands scrambled.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input bit push);
    exp_t e;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = ez;
      sb.push_back(e);
    end
    Start    = 1'b1;
    Signed   = sgn;
    Dividend = a;
    Divisor  = b;
    @(posedge clk);
    #1;
    Start    = 1'b0;
    Signed   = ~sgn;
    Dividend = 32'hDEAD_BEEF;
    Divisor  = 32'h0;
  endtask

  // Count edges after the sampling edge until Done; returns at the Done-cycle negedge.
  task automatic wait_done(input int exp_lat, input string tag);
    int  lat   = 0;
    int  busy  = 0;
    bit  seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (Busy === 1'b1) busy++;
      @(posedge clk);
      lat++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no Done expected Done after %0d edges", tag, exp_lat);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_lat));
      check({tag, "_busy_low_on_done"}, 32'(Busy), 32'd0);
    end
  endtask

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int exp_lat, input string tag);
    start_op(sgn, a, b, eq, er, ez, 1'b1);
    wait_done(exp_lat, tag);
  endtask

  initial begin
    rst      = 1'b0;
    Start    = 1'b0;
    Signed   = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_quotient", Quotient, 32'd0);
    check("reset_remainder", Remainder, 32'd0);
    check("reset_divbyzero", 32'(DivByZero), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned and signed directed divides.
    do_div(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 33, "divu_100_7");
    do_div(1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 33, "div_m7_2");
    do_div(1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 33, "div_7_m2");
    do_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0, 33, "div_m100_m7");
    do_div(1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,        1'b0, 33, "divu_big_2");
    do_div(1'b0, 32'd5,          32'd9,        32'd0,         32'd5,        1'b0, 33, "divu_5_9");

    // Divide by zero, then a clean result clears the flag.
    do_div(1'b0, 32'h00001234,   32'd0,        32'hFFFFFFFF,  32'h00001234, 1'b1, 1,  "dbz_u");
    do_div(1'b1, 32'hFFFFFF00,   32'd0,        32'hFFFFFFFF,  32'hFFFFFF00, 1'b1, 1,  "dbz_s");
    do_div(1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 33, "divu_max_1");

    // Signed overflow, then a new request in the Done cycle.
    do_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 33, "div_ovf");
    start_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    wait_done(33, "b2b_1000_10");

    // Start while busy must be ignored.
    @(posedge clk);
    #1;
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    Start    = 1'b1;
    Signed   = 1'b1;
    Dividend = 32'd55;
    Divisor  = 32'd5;
    @(posedge clk);
    #1;
    Start    = 1'b0;
    wait_done(28, "busy_ignore");
    repeat (40) @(posedge clk);
    #1;

    // Reset mid-run aborts the operation and clears outputs at once.
    start_op(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_quotient", Quotient, 32'd0);
    check("midrst_remainder", Remainder, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "after_rst_9_3");

    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
